// File: rtl/pipe_pkg.sv
// Shared run-state encodings and MIPS opcode/funct constants for the pipeline control slice.
package pipe_pkg;

    // IDLE/RUN encodings are also decoded directly by the decode stage.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        HALT  = 2'b11
    } run_state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_MUL   = 6'd1;
    localparam logic [5:0] FN_JR    = 6'd8;

    // Instructions that actually read rt as a source operand.
    function automatic logic rt_used(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: a lw in EX whose destination feeds a source of the instruction in ID.
module hazard_detect (
    input  logic       dx_memread,
    input  logic [4:0] dx_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       rt_used,
    output logic       stall
);

    assign stall = dx_memread && (dx_rd != 5'd0) &&
                   ((dx_rd == id_rs) || (rt_used && (dx_rd == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Run-state sequencer for the 5-stage pipeline: stage enables, bubbles and flushes,
// mul freeze, halt drain and performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       id_op,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             dx_memread,
    input  logic [4:0]       dx_rd,
    input  logic             ex_redirect,
    output logic [1:0]       curr_state,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    run_state_e    state, state_nxt;
    logic [3:0]    mul_cnt, mul_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          load_use;
    logic          mul_busy;

    hazard_detect u_hazard (
        .dx_memread (dx_memread),
        .dx_rd      (dx_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .rt_used    (rt_used(id_op)),
        .stall      (load_use)
    );

    assign mul_busy   = (mul_cnt != 4'd0);
    assign curr_state = state;

    always_comb begin
        state_nxt    = state;
        mul_nxt      = mul_cnt;
        drain_nxt    = drain_cnt;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_we      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (mul_busy) begin
                    exmem_bubble = 1'b1;
                    mul_nxt      = mul_cnt - 4'd1;
                end else if (ex_redirect) begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                end else if (id_op == OP_HALT) begin
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                    state_nxt   = DRAIN;
                    drain_nxt   = DW'(DRAIN_CYC - 1);
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    if (id_op == OP_RTYPE && id_funct == FN_MUL)
                        mul_nxt = 4'(MUL_LAT - 1);
                end
            end
            DRAIN: begin
                idex_bubble = 1'b1;
                // A mul still occupying EX freezes the drain countdown too.
                if (mul_busy) begin
                    exmem_bubble = 1'b1;
                    mul_nxt      = mul_cnt - 4'd1;
                end else begin
                    idex_we = 1'b1;
                    if (drain_cnt == '0) state_nxt = HALT;
                    else                 drain_nxt = drain_cnt - DW'(1);
                end
            end
            HALT: begin
                done         = 1'b1;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mul_cnt   <= 4'd0;
            drain_cnt <= '0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            mul_cnt   <= mul_nxt;
            drain_cnt <= drain_nxt;
            if (state == RUN || state == DRAIN) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state == RUN && !pc_we)         stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vectors for pipe_hazard_ctrl; stimulus pushes expectations, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, dx_rd;
    logic        dx_memread, ex_redirect;

    logic [1:0]  curr_state;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, done;
    logic [31:0] cycle_cnt, stall_cnt;

    logic [1:0]  w_state;
    logic        w_pc_we, w_ifid_we, w_ifid_flush, w_idex_we, w_idex_bubble, w_exmem_bubble, w_done;
    logic [3:0]  w_cycle_cnt, w_stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .id_op(id_op), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .dx_memread(dx_memread), .dx_rd(dx_rd),
        .ex_redirect(ex_redirect), .curr_state(curr_state), .pc_we(pc_we),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .done(done),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .id_op(id_op), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .dx_memread(dx_memread), .dx_rd(dx_rd),
        .ex_redirect(ex_redirect), .curr_state(w_state), .pc_we(w_pc_we),
        .ifid_we(w_ifid_we), .ifid_flush(w_ifid_flush), .idex_we(w_idex_we),
        .idex_bubble(w_idex_bubble), .exmem_bubble(w_exmem_bubble), .done(w_done),
        .cycle_cnt(w_cycle_cnt), .stall_cnt(w_stall_cnt)
    );

    // en = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, done}
    localparam logic [6:0] E_IDLE = 7'b0010110;
    localparam logic [6:0] E_RUN  = 7'b1101000;
    localparam logic [6:0] E_MUL  = 7'b0000010;
    localparam logic [6:0] E_RDR  = 7'b1111100;
    localparam logic [6:0] E_STL  = 7'b0001100;
    localparam logic [6:0] E_HALT = 7'b0010111;

    typedef struct {
        string      nm;
        logic [1:0] st;
        logic [6:0] en;
        int         cyc;
        int         stl;
        int         cyc4;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic step(input string nm, input logic rst, input logic st_in,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] rd, input logic rdr,
                        input logic [1:0] es, input logic [6:0] een,
                        input int ec, input int estl, input int ec4);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; start = st_in; id_op = op; id_funct = fn; id_rs = rs; id_rt = rt;
        dx_memread = mr; dx_rd = rd; ex_redirect = rdr;
        e.nm = nm; e.st = es; e.en = een; e.cyc = ec; e.stl = estl; e.cyc4 = ec4;
        q.push_back(e);
    endtask

    // Plain addi in ID, nothing interesting in EX.
    task automatic nop(input string nm, input logic st_in, input logic [1:0] es,
                       input logic [6:0] een, input int ec, input int estl);
        step(nm, 1'b1, st_in, 6'd8, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, es, een, ec, estl, -1);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [6:0] en;
            e  = q.pop_front();
            en = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, done};
            vectors++;
            if (curr_state !== e.st) begin
                miscompares++;
                $display("FAIL %s state got %b exp %b", e.nm, curr_state, e.st);
            end
            vectors++;
            if (en !== e.en) begin
                miscompares++;
                $display("FAIL %s en got %b exp %b", e.nm, en, e.en);
            end
            vectors++;
            if (cycle_cnt !== 32'(e.cyc)) begin
                miscompares++;
                $display("FAIL %s cycle_cnt got %0d exp %0d", e.nm, cycle_cnt, e.cyc);
            end
            vectors++;
            if (stall_cnt !== 32'(e.stl)) begin
                miscompares++;
                $display("FAIL %s stall_cnt got %0d exp %0d", e.nm, stall_cnt, e.stl);
            end
            if (e.cyc4 >= 0) begin
                vectors++;
                if (w_cycle_cnt !== 4'(e.cyc4)) begin
                    miscompares++;
                    $display("FAIL %s cycle_cnt4 got %0d exp %0d", e.nm, w_cycle_cnt, e.cyc4);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; id_op = 6'd8; id_funct = 6'd0; id_rs = 5'd1; id_rt = 5'd2;
        dx_memread = 1'b0; dx_rd = 5'd0; ex_redirect = 1'b0;

        step("reset", 1'b0, 1'b0, 6'd8, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 2'b00, E_IDLE, 0, 0, 0);
        nop("idle_start", 1'b1, 2'b00, E_IDLE, 0, 0);
        for (int i = 0; i < 20; i++) nop("run", 1'b0, 2'b01, E_RUN, i, 0);

        // load-use on rs; wrap instance has seen 20 RUN cycles
        step("lu_rs", 1'b1, 1'b0, 6'd0, 6'd32, 5'd3, 5'd5, 1'b1, 5'd3, 1'b0, 2'b01, E_STL, 20, 0, 4);
        nop("lu_after", 1'b0, 2'b01, E_RUN, 21, 1);
        step("lu_rt", 1'b1, 1'b0, 6'd0, 6'd32, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 2'b01, E_STL, 22, 1, -1);
        step("rt_unused", 1'b1, 1'b0, 6'd8, 6'd0, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 2'b01, E_RUN, 23, 2, -1);
        step("rd_zero", 1'b1, 1'b0, 6'd0, 6'd32, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 2'b01, E_RUN, 24, 2, -1);

        // redirect beats load-use and halt
        step("rdr_lu", 1'b1, 1'b0, 6'd0, 6'd32, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 2'b01, E_RDR, 25, 2, -1);
        nop("rdr_after", 1'b0, 2'b01, E_RUN, 26, 2);
        step("rdr_halt", 1'b1, 1'b0, 6'h3F, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01, E_RDR, 27, 2, -1);
        nop("rdr_halt_after", 1'b0, 2'b01, E_RUN, 28, 2);

        // mul: two frozen cycles, redirect ignored during the freeze
        step("mul_issue", 1'b1, 1'b0, 6'd0, 6'd1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 2'b01, E_RUN, 29, 2, -1);
        step("mul_busy1", 1'b1, 1'b0, 6'd8, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 2'b01, E_MUL, 30, 2, -1);
        nop("mul_busy2", 1'b0, 2'b01, E_MUL, 31, 3);
        nop("mul_done", 1'b0, 2'b01, E_RUN, 32, 4);

        // halt and drain; start ignored during DRAIN
        step("halt_id", 1'b1, 1'b0, 6'h3F, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, E_STL, 33, 4, -1);
        nop("drain1", 1'b1, 2'b10, E_STL, 34, 5);
        nop("drain2", 1'b0, 2'b10, E_STL, 35, 5);
        nop("drain3", 1'b0, 2'b10, E_STL, 36, 5);
        nop("halt1", 1'b0, 2'b11, E_HALT, 37, 5);
        nop("halt2", 1'b1, 2'b11, E_HALT, 37, 5);
        nop("restart", 1'b0, 2'b01, E_RUN, 37, 5);

        // async reset in the middle of a mul freeze
        step("mul_issue2", 1'b1, 1'b0, 6'd0, 6'd1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 2'b01, E_RUN, 38, 5, -1);
        step("rst_mid_mul", 1'b0, 1'b0, 6'd8, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 2'b00, E_IDLE, 0, 0, 0);
        nop("rst_start", 1'b1, 2'b00, E_IDLE, 0, 0);
        nop("run_no_freeze", 1'b0, 2'b01, E_RUN, 0, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue left %0d exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). Owns the run state (the curr_state consumed by the decode stage and register file write gating). Generates all stage write-enables, bubbles and flushes for load-use hazards, EX-resolved control flow (beq/j/jal/jr) and the multi-cycle mul. Also controls halt/drain and keeps performance counters.

Parameters:
MUL_LAT, 3, EX-stage cycles occupied by mul (funct 6'd1); legal range 1..15.
DRAIN_CYC, 3, cycles after halt detection before HALT (EX+MEM+WB retire).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; begin execution from IDLE or HALT
id_op  in  6  IR[31:26] of the instruction in ID
id_funct  in  6  IR[5:0] of the instruction in ID
id_rs  in  5  IR[25:21] in ID
id_rt  in  5  IR[20:16] in ID
dx_memread  in  1  ID/EX MemRead (lw in EX)
dx_rd  in  5  ID/EX destination register
ex_redirect  in  1  EX resolved taken beq, j, jal or jr this cycle
curr_state  out  2  00 IDLE, 01 RUN, 10 DRAIN, 11 HALT
pc_we  out  1  PC register update enable
ifid_we  out  1  IF/ID pipeline register enable
ifid_flush  out  1  load NOP into IF/ID
idex_we  out  1  ID/EX pipeline register enable
idex_bubble  out  1  load NOP controls (RegWrite/MemWrite/MemRead/branch/jump=0) into ID/EX
exmem_bubble  out  1  load NOP into EX/MEM
done  out  1  high in HALT
cycle_cnt  out  CNT_W  cycles spent in RUN or DRAIN
stall_cnt  out  CNT_W  cycles with pc_we=0 while in RUN

Behaviour:
- Reset (async, rst_n=0): state IDLE, mul_cnt=0, drain_cnt=0, counters 0. Outputs while in reset: pc_we=ifid_we=idex_we=0, idex_bubble=exmem_bubble=1, ifid_flush=1, done=0.
- State register, mul_cnt and drain_cnt are registered. Enables, bubbles and flushes are combinational from state, counters and inputs (zero latency to the pipeline registers).
- IDLE: all enables 0, bubbles/flush 1. start=1 -> RUN next edge.
- RUN: evaluate in strict priority:
  1. mul_busy (mul_cnt!=0): pc_we=ifid_we=idex_we=0, exmem_bubble=1. mul_cnt decrements each cycle. ex_redirect is ignored while busy.
  2. ex_redirect: pc_we=1, ifid_flush=1, idex_bubble=1. Flushes the two younger instructions. Overrides load-use and halt detection in ID.
  3. load-use: dx_memread && dx_rd!=0 && (dx_rd==id_rs || (rt_used && dx_rd==id_rt)). rt_used holds for op 0, 4, 43. Action: pc_we=ifid_we=0, idex_bubble=1. Exactly one stall cycle per hazard.
  4. halt: id_op==6'h3F. Action: pc_we=ifid_we=0, idex_bubble=1; next state DRAIN, drain_cnt=DRAIN_CYC-1.
  5. else all enables 1, no bubbles.
- mul issue: id_op==0 && id_funct==1 passing ID->EX (case 5, idex_we=1) loads mul_cnt=MUL_LAT-1. With MUL_LAT=1 there is no freeze.
- DRAIN: pc_we=ifid_we=0, idex_bubble=1. EX/MEM/WB keep running, including any remaining mul_busy freeze of EX, in which case drain_cnt holds. drain_cnt==0 -> HALT.
- HALT: done=1, all enables 0. start=1 -> RUN next edge. PC re-init is external.
- start is ignored in RUN and DRAIN.
- Counters wrap at 2^CNT_W. cycle_cnt increments in RUN and DRAIN. stall_cnt increments in RUN when pc_we=0.

Decomposition:
- Shared package pipe_pkg: state encodings IDLE/RUN/DRAIN/HALT (IDLE=2'b00, RUN=2'b01, matching decode-stage usage), opcode constants OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_ADDI=8, OP_LW=35, OP_SW=43, OP_HALT=6'h3F, FN_MUL=1, FN_JR=8.
- One natural sub-module: hazard_detect, the combinational load-use compare (id_rs, id_rt, rt_used, dx_memread, dx_rd -> stall).

Test Plan:
- Reset/start: rst_n low mid-RUN with mul_cnt=2 -> immediately IDLE, all enables 0, counters 0. start=1 -> curr_state=01 next edge, pc_we=1.
- Load-use: lw $3 in EX (dx_memread=1, dx_rd=3), ID add rs=3 -> one cycle pc_we=0, idex_bubble=1, stall_cnt+1. Same with dx_rd=0 -> no stall.
- Redirect vs load-use: ex_redirect=1 with a load-use hazard in the same cycle -> pc_we=1, ifid_flush=1, idex_bubble=1, stall_cnt unchanged.
- mul: MUL_LAT=3, issue mul -> exactly 2 following cycles with pc_we=ifid_we=idex_we=0 and exmem_bubble=1. ex_redirect asserted during the freeze is ignored.
- Halt: ID op=6'h3F -> DRAIN for 3 cycles, then HALT with done=1. cycle_cnt stops. start=1 -> RUN.
- Counter wrap: CNT_W=4, 20 RUN cycles -> cycle_cnt=4.
